// File: rtl/fifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_sync_ctrl
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// levels and sticky overflow/underflow flags. The storage is a register array
// with synchronous write and asynchronous read.
//
// Optional feature macro: FIFO_FWFT_EN
//   defined   : first-word-fall-through; the head word is shown on rd_data with
//               rd_valid = !empty, and rd_en pops it.
//   undefined : registered read; rd_data loads at the accepting edge and
//               rd_valid pulses for the following cycle.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   wr_en        write request          wr_data   write word
//   rd_en        read request / pop     rd_data   read word
//   rd_valid     rd_data qualifier
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= af_level      almost_empty  count <= ae_level
//   af_level     almost-full threshold  ae_level      almost-empty threshold
//   count        occupancy 0..DEPTH
//   overflow     sticky, write while full
//   underflow    sticky, read while empty
//   clr_err      clears both sticky flags
// -----------------------------------------------------------------------------
module fifo_sync_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    input  logic [ADDR_SIZE:0]   af_level,
    input  logic [ADDR_SIZE:0]   ae_level,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clr_err
);

    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] ZERO_C  = {(ADDR_SIZE + 1){1'b0}};
    localparam logic [ADDR_SIZE:0] ONE_C   = {{ADDR_SIZE{1'b0}}, 1'b1};

    // The extra pointer wrap bit only works if the array spans the full address space.
    if (DEPTH != (1 << ADDR_SIZE)) begin : g_depth_chk
        $error("fifo_sync_ctrl: DEPTH must equal 2**ADDR_SIZE");
    end

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [ADDR_SIZE:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 full_s, empty_s;
    logic                 wr_acc_s, rd_acc_s;

    // Status decode from the count register, accept qualification and next state.
    always_comb begin
        full_s   = (count_q == DEPTH_C);
        empty_s  = (count_q == ZERO_C);
        wr_acc_s = wr_en && !full_s;
        rd_acc_s = rd_en && !empty_s;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // A simultaneous accepted read and write leaves the occupancy unchanged.
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // Error events win over a coincident clear.
        if (wr_en && full_s) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (rd_en && empty_s) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Pointer, occupancy and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= ZERO_C;
            rd_ptr_q    <= ZERO_C;
            count_q     <= ZERO_C;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_q[wr_ptr_q[ADDR_SIZE-1:0]] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through; valid whenever anything is stored.
    always_comb begin
        rd_data  = mem_q[rd_ptr_q[ADDR_SIZE-1:0]];
        rd_valid = !empty_s;
    end
`else
    logic [DATA_SIZE-1:0] rd_data_q;
    logic                 rd_valid_q;

    // Registered read port: data loads on an accepted read and is held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= {DATA_SIZE{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data_q <= mem_q[rd_ptr_q[ADDR_SIZE-1:0]];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_q >= af_level);
    assign almost_empty = (count_q <= ae_level);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_sync_ctrl. A queue-based reference model is updated by the
// stimulus process at each rising edge; a separate monitor compares the DUT
// outputs against the model a few time units after every rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_sync_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = 8'h00;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   af_level = 5'd14;
    logic [AW:0]   ae_level = 5'd2;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic          clr_err = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .af_level(af_level), .ae_level(ae_level), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    // Reference model state
    logic [DW-1:0] m_q[$];     // words stored in the FIFO, head at index 0
    logic [DW-1:0] exp_q[$];   // words expected on rd_data (registered mode)
    bit            m_ovf, m_udf, m_rdv;
    logic [DW-1:0] m_last;
    bit            started = 1'b0;
    bit            done = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus the model update for that edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input bit rs);
        bit wacc, racc;
        @(negedge clk);
        wr_en = w; wr_data = d; rd_en = r; clr_err = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            m_q.delete(); exp_q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_rdv = 1'b0; m_last = 8'h00;
            started = 1'b1;
        end else begin
            wacc = w && (m_q.size() < DEPTH);
            racc = r && (m_q.size() > 0);
            m_rdv = racc;
            if (racc) begin
                m_last = m_q.pop_front();
                exp_q.push_back(m_last);
            end
            if (wacc) m_q.push_back(d);
            if (w && !wacc) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
            if (r && !racc) m_udf = 1'b1; else if (c) m_udf = 1'b0;
        end
    endtask

    // Monitor: compares all outputs against the model once per cycle.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            #3;
            if (started && !done) begin
                chk("count", count, m_q.size());
                chk("full", full, m_q.size() == DEPTH);
                chk("empty", empty, m_q.size() == 0);
                chk("almost_full", almost_full, m_q.size() >= int'(af_level));
                chk("almost_empty", almost_empty, m_q.size() <= int'(ae_level));
                chk("overflow", overflow, m_ovf);
                chk("underflow", underflow, m_udf);
`ifdef FIFO_FWFT_EN
                chk("rd_valid", rd_valid, m_q.size() > 0);
                if (m_q.size() > 0) chk("rd_data_head", rd_data, m_q[0]);
`else
                chk("rd_valid", rd_valid, m_rdv);
                if (rd_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("rd_valid_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", rd_data, e);
                    end
                end else begin
                    chk("rd_data_hold", rd_data, m_last);
                end
`endif
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        // Reset and reset-state checks
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_count", count, 5'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);

        // Fill with 0x01..0x10, then one dropped write
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        #1;
        chk("fill_count", count, 5'd16);
        chk("fill_full", full, 1'b1);
        chk("fill_af", almost_full, 1'b1);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        #1;
        chk("fill_overflow", overflow, 1'b1);

        // Drain, then one read on empty
        for (int i = 1; i <= 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("drain_empty", empty, 1'b1);
        chk("drain_underflow", underflow, 1'b1);

        // clr_err without an error event
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        #1;
        chk("clr_overflow", overflow, 1'b0);
        chk("clr_underflow", underflow, 1'b0);

        // Wrap stress at count 3
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        #1;
        chk("wrap_count", count, 5'd3);

        // Simultaneous read/write at full and at empty
        for (int i = 0; i < 13; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rw_full_count", count, 5'd15);
        chk("rw_full_ovf", overflow, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rw_empty_count", count, 5'd1);
        chk("rw_empty_udf", underflow, 1'b1);

        // clr_err coincident with an overflow event
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        #1;
        chk("clr_vs_ovf", overflow, 1'b1);

        // FWFT fall-through of a word into an empty FIFO
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
        #1;
        chk("fwft_valid", rd_valid, 1'b1);
        chk("fwft_data", rd_data, 8'hA5);
`endif
        // Mid-operation reset with 5 words stored
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        chk("midrst_count", count, 5'd0);
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_valid", rd_valid, 1'b0);

        // Randomised traffic with varying thresholds
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) begin
                af_level = 5'($urandom_range(0, 31));
                ae_level = 5'($urandom_range(0, 31));
            end
            r = $urandom_range(0, 99);
            step(($urandom_range(0, 99) < (r < 50 ? 70 : 35)), 8'($urandom),
                 ($urandom_range(0, 99) < (r < 50 ? 35 : 70)),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) == 0));
        end

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #4;
`ifndef FIFO_FWFT_EN
        chk("scoreboard_drained", exp_q.size(), 0);
`endif
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
